// File: rtl/osc_timebase_ctrl.sv
// osc_timebase_ctrl: oscilloscope time/div owner.
// Debounces the up/down buttons, stages a new time/div setting and applies
// it on a frame boundary, and generates the ADC sample-enable strobe for the
// applied setting.
// Optional build macro TIMEBASE_WRAP_EN: when defined, stepping past either
// end of the 1/2/5/10 ms table wraps to the other end instead of saturating.
module osc_timebase_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BASE_DIV        = 1080,
    parameter int CNT_W           = 24
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BTN_UP,
    input  logic             BTN_DOWN,
    input  logic             VGA_frameStart,
    output logic             SAMPLE_EN,
    output logic [1:0]       TIMEBASE_SEL,
    output logic [CNT_W-1:0] SAMPLE_DIV,
    output logic             CHANGE_PENDING
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Divisor table, fixed at elaboration.
    localparam logic [CNT_W-1:0] DIV_1MS  = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] DIV_2MS  = CNT_W'(2 * BASE_DIV);
    localparam logic [CNT_W-1:0] DIV_5MS  = CNT_W'(5 * BASE_DIV);
    localparam logic [CNT_W-1:0] DIV_10MS = CNT_W'(10 * BASE_DIV);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    // Button vectors: bit 0 = up, bit 1 = down.
    logic [1:0]            btn_meta;
    logic [1:0]            btn_sync;
    logic [1:0]            btn_deb;
    logic [1:0]            btn_deb_d;
    logic [1:0][DB_W-1:0]  db_cnt;
    logic [1:0]            btn_req;
    logic                  up_req;
    logic                  down_req;

    state_t                state;
    state_t                state_n;
    logic [1:0]            pend_idx;
    logic [1:0]            pend_n;
    logic [1:0]            cur_idx;
    logic [1:0]            target_idx;
    logic                  single_req;
    logic [CNT_W-1:0]      sample_cnt;

    function automatic logic [CNT_W-1:0] div_for(input logic [1:0] idx);
        case (idx)
            2'd0:    return DIV_1MS;
            2'd1:    return DIV_2MS;
            2'd2:    return DIV_5MS;
            default: return DIV_10MS;
        endcase
    endfunction

    function automatic logic [1:0] step_up(input logic [1:0] idx);
`ifdef TIMEBASE_WRAP_EN
        return idx + 2'd1;
`else
        return (idx == 2'd3) ? idx : idx + 2'd1;
`endif
    endfunction

    function automatic logic [1:0] step_down(input logic [1:0] idx);
`ifdef TIMEBASE_WRAP_EN
        return idx - 2'd1;
`else
        return (idx == 2'd0) ? idx : idx - 2'd1;
`endif
    endfunction

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values and simulation order cannot create races.
        if (RESET) begin
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            btn_meta <= {BTN_DOWN, BTN_UP};
            btn_sync <= btn_meta;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            db_cnt    <= '0;
            btn_deb   <= '0;
            btn_deb_d <= '0;
        end else begin
            btn_deb_d <= btn_deb;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync[i] == btn_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_deb[i] <= btn_sync[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press is the rising edge of the debounced level.
    assign btn_req  = btn_deb & ~btn_deb_d;
    assign up_req   = btn_req[0];
    assign down_req = btn_req[1];

    // Next-state logic: resolve requests against the staged or applied index.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave one unassigned and infer a latch.
        state_n    = state;
        pend_n     = pend_idx;
        single_req = up_req ^ down_req;
        cur_idx    = (state == ST_PENDING) ? pend_idx : TIMEBASE_SEL;
        target_idx = up_req ? step_up(cur_idx) : step_down(cur_idx);

        case (state)
            ST_IDLE: begin
                if (single_req && (target_idx != TIMEBASE_SEL)) begin
                    state_n = ST_PENDING;
                    pend_n  = target_idx;
                end
            end
            ST_PENDING: begin
                if (single_req) begin
                    pend_n = target_idx;
                end
                if (VGA_frameStart) begin
                    state_n = ST_APPLY;
                end else if (single_req && (target_idx == TIMEBASE_SEL)) begin
                    state_n = ST_IDLE;
                end
            end
            ST_APPLY: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register and applied setting; the setting only changes out of APPLY.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= ST_IDLE;
            pend_idx       <= 2'd0;
            TIMEBASE_SEL   <= 2'd0;
            SAMPLE_DIV     <= DIV_1MS;
            CHANGE_PENDING <= 1'b0;
        end else begin
            state          <= state_n;
            pend_idx       <= pend_n;
            CHANGE_PENDING <= (state_n != ST_IDLE);
            if (state == ST_APPLY) begin
                TIMEBASE_SEL <= pend_idx;
                SAMPLE_DIV   <= div_for(pend_idx);
            end
        end
    end

    // Sample divider; restarts on apply so no strobe comes from a stale count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sample_cnt <= '0;
            SAMPLE_EN  <= 1'b0;
        end else if (state == ST_APPLY) begin
            sample_cnt <= '0;
            SAMPLE_EN  <= 1'b0;
        end else if (sample_cnt == SAMPLE_DIV - CNT_W'(1)) begin
            sample_cnt <= '0;
            SAMPLE_EN  <= 1'b1;
        end else begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            SAMPLE_EN  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_osc_timebase_ctrl.sv
// Self-checking bench for osc_timebase_ctrl with DEBOUNCE_CYCLES=4, BASE_DIV=3.
// A behavioural model tracks the expected outputs from button histories,
// frame pulses and the time since the last reset/apply; directed checks pin
// hand-computed values at key points.
module tb_osc_timebase_ctrl;

    localparam int DB    = 4;
    localparam int BDIV  = 3;
    localparam int CW    = 24;

    logic          clk;
    logic          RESET;
    logic          BTN_UP;
    logic          BTN_DOWN;
    logic          VGA_frameStart;
    logic          SAMPLE_EN;
    logic [1:0]    TIMEBASE_SEL;
    logic [CW-1:0] SAMPLE_DIV;
    logic          CHANGE_PENDING;

    int total = 0;
    int bad   = 0;

    osc_timebase_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .BASE_DIV(BDIV),
        .CNT_W(CW)
    ) dut (
        .CLK(clk),
        .RESET(RESET),
        .BTN_UP(BTN_UP),
        .BTN_DOWN(BTN_DOWN),
        .VGA_frameStart(VGA_frameStart),
        .SAMPLE_EN(SAMPLE_EN),
        .TIMEBASE_SEL(TIMEBASE_SEL),
        .SAMPLE_DIV(SAMPLE_DIV),
        .CHANGE_PENDING(CHANGE_PENDING)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_edge      = 0;
    int  a_edge      = 0;     // edge at which the sample count last restarted
    bit  model_valid = 1'b0;
    int  sel_m, pend_m;
    bit  pend_f, apply_f;
    bit  up_d1, up_d2, dn_d1, dn_d2;
    bit  deb_up, deb_dn;
    int  up_req_edge, dn_req_edge;
    bit  win_up[$];
    bit  win_dn[$];
    bit  su, sd, up_now, dn_now, one;
    int  base, tgt;

    function automatic int mult(input int idx);
        case (idx)
            0: return 1;
            1: return 2;
            2: return 5;
            default: return 10;
        endcase
    endfunction

    function automatic int nxt_up(input int b);
`ifdef TIMEBASE_WRAP_EN
        return (b + 1) % 4;
`else
        return (b < 3) ? b + 1 : 3;
`endif
    endfunction

    function automatic int nxt_dn(input int b);
`ifdef TIMEBASE_WRAP_EN
        return (b + 3) % 4;
`else
        return (b > 0) ? b - 1 : 0;
`endif
    endfunction

    function automatic bit all_differ(input bit q[$], input bit v);
        if (q.size() < DB) return 1'b0;
        foreach (q[i]) if (q[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        m_edge++;
        if (RESET) begin
            model_valid = 1'b1;
            a_edge  = m_edge;
            sel_m   = 0;
            pend_m  = 0;
            pend_f  = 1'b0;
            apply_f = 1'b0;
            up_d1 = 0; up_d2 = 0; dn_d1 = 0; dn_d2 = 0;
            deb_up = 0; deb_dn = 0;
            up_req_edge = -1;
            dn_req_edge = -1;
            win_up.delete();
            win_dn.delete();
        end else begin
            su = up_d2; up_d2 = up_d1; up_d1 = BTN_UP;
            sd = dn_d2; dn_d2 = dn_d1; dn_d1 = BTN_DOWN;
            up_now = (up_req_edge == m_edge);
            dn_now = (dn_req_edge == m_edge);

            // A level is accepted once the last DB synced samples all disagree.
            win_up.push_back(su);
            if (win_up.size() > DB) void'(win_up.pop_front());
            if (all_differ(win_up, deb_up)) begin
                deb_up = !deb_up;
                if (deb_up) up_req_edge = m_edge + 1;
                win_up.delete();
            end
            win_dn.push_back(sd);
            if (win_dn.size() > DB) void'(win_dn.pop_front());
            if (all_differ(win_dn, deb_dn)) begin
                deb_dn = !deb_dn;
                if (deb_dn) dn_req_edge = m_edge + 1;
                win_dn.delete();
            end

            if (apply_f) begin
                sel_m   = pend_m;
                a_edge  = m_edge;
                apply_f = 1'b0;
                pend_f  = 1'b0;
            end else begin
                one  = up_now ^ dn_now;
                base = pend_f ? pend_m : sel_m;
                tgt  = up_now ? nxt_up(base) : nxt_dn(base);
                if (pend_f) begin
                    if (one) pend_m = tgt;
                    if (VGA_frameStart) apply_f = 1'b1;
                    else if (one && tgt == sel_m) pend_f = 1'b0;
                end else if (one && tgt != sel_m) begin
                    pend_f = 1'b1;
                    pend_m = tgt;
                end
            end
        end
    end

    // Compare process: every cycle after the first reset edge.
    int exp_div;
    bit exp_en;
    always @(negedge clk) begin
        if (model_valid) begin
            exp_div = BDIV * mult(sel_m);
            exp_en  = (m_edge > a_edge) && (((m_edge - a_edge) % exp_div) == 0);
            check("model_sample_en", SAMPLE_EN, exp_en);
            check("model_sel", TIMEBASE_SEL, sel_m);
            check("model_div", SAMPLE_DIV, exp_div);
            check("model_pending", CHANGE_PENDING, pend_f || apply_f);
        end
    end

    // Watches for an intermediate index during the double-press scenario.
    bit watch_one = 1'b0;
    bit saw_one   = 1'b0;
    always @(negedge clk) if (watch_one && TIMEBASE_SEL == 2'd1) saw_one = 1'b1;

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit up, input bit dn, input int n);
        BTN_UP = up; BTN_DOWN = dn;
        tick(n);
        BTN_UP = 1'b0; BTN_DOWN = 1'b0;
    endtask

    task automatic frame_pulse();
        VGA_frameStart = 1'b1;
        tick(1);
        VGA_frameStart = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
    endtask

    initial begin
        int strobes;
        int w;
        RESET = 1'b1; BTN_UP = 1'b0; BTN_DOWN = 1'b0; VGA_frameStart = 1'b0;
        tick(3);
        check("rst_sel", TIMEBASE_SEL, 0);
        check("rst_div", SAMPLE_DIV, 3);
        check("rst_en", SAMPLE_EN, 0);
        check("rst_pending", CHANGE_PENDING, 0);
        RESET = 1'b0;

        // Free run: period 3 gives exactly 10 strobes in 30 cycles.
        strobes = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (SAMPLE_EN) strobes++;
        end
        check("free_run_strobes", strobes, 10);
        check("free_run_pending", CHANGE_PENDING, 0);

        // Single UP press, frame 20 cycles later.
        press(1'b1, 1'b0, 10);
        check("up_pending", CHANGE_PENDING, 1);
        check("up_sel_held", TIMEBASE_SEL, 0);
        tick(20);
        check("up_pending_hold", CHANGE_PENDING, 1);
        frame_pulse();
        check("apply_cycle_pending", CHANGE_PENDING, 1);
        check("apply_cycle_sel", TIMEBASE_SEL, 0);
        tick(1);
        check("up_sel", TIMEBASE_SEL, 1);
        check("up_div", SAMPLE_DIV, 6);
        check("up_pending_clr", CHANGE_PENDING, 0);
        w = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (SAMPLE_EN) begin w = i; break; end
        end
        check("first_strobe_delay", w, 6);
        w = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (SAMPLE_EN) begin w = i; break; end
        end
        check("strobe_period_6", w, 6);

        // Two UP presses from index 0, applied once.
        do_reset();
        watch_one = 1'b1;
        press(1'b1, 1'b0, 6);
        tick(10);
        check("two_up_pending", CHANGE_PENDING, 1);
        press(1'b1, 1'b0, 6);
        tick(12);
        frame_pulse();
        tick(1);
        check("two_up_sel", TIMEBASE_SEL, 2);
        check("two_up_div", SAMPLE_DIV, 15);
        tick(5);
        watch_one = 1'b0;
        check("no_intermediate_1", saw_one, 0);

        // Glitch and simultaneous press are both ignored.
        press(1'b1, 1'b0, 2);
        tick(10);
        check("glitch_pending", CHANGE_PENDING, 0);
        press(1'b1, 1'b1, 8);
        tick(12);
        check("both_pending", CHANGE_PENDING, 0);
        frame_pulse();
        tick(3);
        check("both_sel", TIMEBASE_SEL, 2);

        // DOWN at index 0.
        do_reset();
        press(1'b0, 1'b1, 8);
        tick(10);
`ifdef TIMEBASE_WRAP_EN
        check("down0_pending", CHANGE_PENDING, 1);
        frame_pulse();
        tick(1);
        check("down0_sel", TIMEBASE_SEL, 3);
        check("down0_div", SAMPLE_DIV, 30);
`else
        check("down0_pending", CHANGE_PENDING, 0);
        frame_pulse();
        tick(1);
        check("down0_sel", TIMEBASE_SEL, 0);
        check("down0_div", SAMPLE_DIV, 3);
`endif

        // UP then DOWN returns to the applied index and cancels the change.
        do_reset();
        press(1'b1, 1'b0, 6);
        tick(10);
        check("cancel_up_pending", CHANGE_PENDING, 1);
        press(1'b0, 1'b1, 6);
        tick(10);
        check("cancel_pending", CHANGE_PENDING, 0);

        // Accepted UP abandoned by reset; a later frame applies nothing.
        press(1'b1, 1'b0, 6);
        tick(10);
        check("pre_reset_pending", CHANGE_PENDING, 1);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        check("mid_reset_sel", TIMEBASE_SEL, 0);
        check("mid_reset_pending", CHANGE_PENDING, 0);
        check("mid_reset_div", SAMPLE_DIV, 3);
        frame_pulse();
        tick(3);
        check("post_reset_sel", TIMEBASE_SEL, 0);
        check("post_reset_pending", CHANGE_PENDING, 0);

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
